// File: rtl/execution_unit.sv
// rtl/execution_unit.sv - RV32I execute stage: operand select, ALU, branch decision, JALR target
// Combinational datapath; the clock only advances the cycle counter behind the debug trace.
module execution_unit #(
    parameter int CORE         = 0,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 20
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [2:0]              ALU_Operation,
    input  logic [2:0]              funct3,
    input  logic [6:0]              funct7,
    input  logic [ADDRESS_BITS-1:0] PC,
    input  logic [1:0]              ALU_ASrc,
    input  logic                    ALU_BSrc,
    input  logic                    branch_op,
    input  logic [DATA_WIDTH-1:0]   regRead_1,
    input  logic [DATA_WIDTH-1:0]   regRead_2,
    input  logic [DATA_WIDTH-1:0]   extend,
    output logic [DATA_WIDTH-1:0]   ALU_result,
    output logic                    zero,
    output logic                    branch,
    output logic [ADDRESS_BITS-1:0] JALR_target,
    input  logic                    report
);

    typedef enum logic [3:0] {
        F_ADD, F_SUB, F_SLL, F_SLT, F_SLTU, F_XOR, F_SRL, F_SRA,
        F_OR, F_AND, F_PASSA, F_PASSB, F_BR
    } alu_fn_e;

    logic [DATA_WIDTH-1:0] pc_ext;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic [DATA_WIDTH-1:0] jalr_sum;
    logic [4:0]            shamt;
    logic                  lt_s;
    logic                  lt_u;
    logic                  eq;
    logic                  br_cond;
    alu_fn_e               fn;
    logic [31:0]           cycle_q;
    logic [31:0]           cycle_d;
    logic                  unused_bits;

    function automatic alu_fn_e decode_f3(input logic alt, input logic [2:0] f3);
        case (f3)
            3'b000:  decode_f3 = alt ? F_SUB : F_ADD;
            3'b001:  decode_f3 = F_SLL;
            3'b010:  decode_f3 = F_SLT;
            3'b011:  decode_f3 = F_SLTU;
            3'b100:  decode_f3 = F_XOR;
            3'b101:  decode_f3 = alt ? F_SRA : F_SRL;
            3'b110:  decode_f3 = F_OR;
            default: decode_f3 = F_AND;
        endcase
    endfunction

    assign pc_ext = {{(DATA_WIDTH-ADDRESS_BITS){1'b0}}, PC};

    always_comb begin
        op_a = regRead_1;
        case (ALU_ASrc)
            2'b00:   op_a = regRead_1;
            2'b01:   op_a = pc_ext;
            2'b10:   op_a = pc_ext + DATA_WIDTH'(4);
            default: op_a = '0;
        endcase
    end

    assign op_b  = ALU_BSrc ? extend : regRead_2;
    assign shamt = op_b[4:0];
    assign lt_s  = $signed(op_a) < $signed(op_b);
    assign lt_u  = op_a < op_b;
    assign eq    = op_a == op_b;

    always_comb begin
        fn = F_ADD;
        case (ALU_Operation)
            3'b000:  fn = decode_f3(funct7[5], funct3);
            // I-type only honours funct7[5] for SRAI; there is no SUBI
            3'b001:  fn = decode_f3(funct7[5] && (funct3 == 3'b101), funct3);
            3'b011:  fn = F_PASSA;
            3'b100:  fn = F_BR;
            3'b101:  fn = F_PASSB;
            default: fn = F_ADD;
        endcase
    end

    always_comb begin
        br_cond = 1'b0;
        case (funct3)
            3'b000:  br_cond = eq;
            3'b001:  br_cond = !eq;
            3'b100:  br_cond = lt_s;
            3'b101:  br_cond = !lt_s;
            3'b110:  br_cond = lt_u;
            3'b111:  br_cond = !lt_u;
            default: br_cond = 1'b0;
        endcase
    end

    always_comb begin
        ALU_result = '0;
        case (fn)
            F_ADD:   ALU_result = op_a + op_b;
            F_SUB:   ALU_result = op_a - op_b;
            F_SLL:   ALU_result = op_a << shamt;
            F_SLT:   ALU_result = {{(DATA_WIDTH-1){1'b0}}, lt_s};
            F_SLTU:  ALU_result = {{(DATA_WIDTH-1){1'b0}}, lt_u};
            F_XOR:   ALU_result = op_a ^ op_b;
            F_SRL:   ALU_result = op_a >> shamt;
            F_SRA:   ALU_result = DATA_WIDTH'($signed(op_a) >>> shamt);
            F_OR:    ALU_result = op_a | op_b;
            F_AND:   ALU_result = op_a & op_b;
            F_PASSA: ALU_result = op_a;
            F_PASSB: ALU_result = op_b;
            F_BR:    ALU_result = {{(DATA_WIDTH-1){1'b0}}, br_cond};
            default: ALU_result = '0;
        endcase
    end

    assign zero        = (ALU_result == '0);
    assign branch      = branch_op && (ALU_Operation == 3'b100) && ALU_result[0];
    assign jalr_sum    = regRead_1 + extend;
    assign JALR_target = {jalr_sum[ADDRESS_BITS-1:1], 1'b0};
    assign unused_bits = ^{funct7[6], funct7[4:0], jalr_sum[DATA_WIDTH-1:ADDRESS_BITS], jalr_sum[0]};

    assign cycle_d = cycle_q + 32'd1;

    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_d;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clock) begin
        if (report && !reset) begin
            $display("CORE %0d cycle %0d op=%b f3=%b f7=%b A=%h B=%h result=%h zero=%b branch=%b jalr=%h",
                     CORE, cycle_q, ALU_Operation, funct3, funct7, op_a, op_b,
                     ALU_result, zero, branch, JALR_target);
        end
    end
`endif

endmodule

// File: tb/tb_execution_unit.sv
// tb/tb_execution_unit.sv - directed scoreboard bench for execution_unit
module tb_execution_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  ALU_Operation;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [19:0] PC;
    logic [1:0]  ALU_ASrc;
    logic        ALU_BSrc;
    logic        branch_op;
    logic [31:0] regRead_1;
    logic [31:0] regRead_2;
    logic [31:0] extend;
    logic [31:0] ALU_result;
    logic        zero;
    logic        branch;
    logic [19:0] JALR_target;
    logic        report;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [31:0] res;
        logic        z;
        logic        br;
        logic [19:0] jalr;
    } exp_t;

    exp_t sb[$];

    execution_unit #(.CORE(0), .DATA_WIDTH(32), .ADDRESS_BITS(20)) dut (
        .clock(clock), .reset(reset), .ALU_Operation(ALU_Operation), .funct3(funct3),
        .funct7(funct7), .PC(PC), .ALU_ASrc(ALU_ASrc), .ALU_BSrc(ALU_BSrc),
        .branch_op(branch_op), .regRead_1(regRead_1), .regRead_2(regRead_2),
        .extend(extend), .ALU_result(ALU_result), .zero(zero), .branch(branch),
        .JALR_target(JALR_target), .report(report)
    );

    always #5 clock = ~clock;

    task automatic drive(input string tag, input logic [2:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [1:0] asrc, input logic bsrc,
                         input logic bop, input logic [19:0] pc, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [31:0] ext,
                         input logic [31:0] res, input logic br);
        exp_t e;
        ALU_Operation = op;  funct3 = f3;  funct7 = f7;  ALU_ASrc = asrc;
        ALU_BSrc = bsrc;  branch_op = bop;  PC = pc;
        regRead_1 = rs1;  regRead_2 = rs2;  extend = ext;
        e.tag  = tag;
        e.res  = res;
        e.z    = (res == 32'd0);
        e.br   = br;
        e.jalr = 20'((rs1 + ext) & 32'h000F_FFFE);
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        #1;
        e = sb.pop_front();
        checks++;
        assert (ALU_result === e.res) else begin
            failures++;
            $error("FAIL %s result observed=%h expected=%h", e.tag, ALU_result, e.res);
        end
        checks++;
        assert (zero === e.z) else begin
            failures++;
            $error("FAIL %s zero observed=%b expected=%b", e.tag, zero, e.z);
        end
        checks++;
        assert (branch === e.br) else begin
            failures++;
            $error("FAIL %s branch observed=%b expected=%b", e.tag, branch, e.br);
        end
        checks++;
        assert (JALR_target === e.jalr) else begin
            failures++;
            $error("FAIL %s jalr observed=%h expected=%h", e.tag, JALR_target, e.jalr);
        end
    endtask

    task automatic check_cycle(input string tag, input logic [31:0] expv);
        checks++;
        assert (dut.cycle_q === expv) else begin
            failures++;
            $error("FAIL %s cycle observed=%0d expected=%0d", tag, dut.cycle_q, expv);
        end
    endtask

    initial begin
        reset = 1'b1;
        report = 1'b0;

        drive("srl",   3'b000, 3'b101, 7'h00, 2'b00, 1'b0, 1'b0, 20'h0, 32'd5, 32'd7, 32'd0, 32'd0, 1'b0); check_out();
        drive("sub",   3'b000, 3'b000, 7'h20, 2'b00, 1'b0, 1'b0, 20'h0, 32'd5, 32'd7, 32'd0, 32'hFFFF_FFFE, 1'b0); check_out();
        drive("addi",  3'b001, 3'b000, 7'h00, 2'b00, 1'b1, 1'b0, 20'h0, 32'd5, 32'd0, 32'd7, 32'd12, 1'b0); check_out();
        drive("addi_f7", 3'b001, 3'b000, 7'h20, 2'b00, 1'b1, 1'b0, 20'h0, 32'd5, 32'd0, 32'd7, 32'd12, 1'b0); check_out();
        drive("srai",  3'b001, 3'b101, 7'h20, 2'b00, 1'b1, 1'b0, 20'h0, 32'h8000_0000, 32'd0, 32'd4, 32'hF800_0000, 1'b0); check_out();
        drive("sra_r", 3'b000, 3'b101, 7'h20, 2'b00, 1'b0, 1'b0, 20'h0, 32'hF000_0000, 32'h24, 32'd0, 32'hFF00_0000, 1'b0); check_out();
        drive("sll",   3'b000, 3'b001, 7'h00, 2'b00, 1'b0, 1'b0, 20'h0, 32'h1, 32'h3F, 32'd0, 32'h8000_0000, 1'b0); check_out();
        drive("slt",   3'b000, 3'b010, 7'h00, 2'b00, 1'b0, 1'b0, 20'h0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd1, 1'b0); check_out();
        drive("sltu",  3'b000, 3'b011, 7'h00, 2'b00, 1'b0, 1'b0, 20'h0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b0); check_out();
        drive("xor",   3'b000, 3'b100, 7'h00, 2'b00, 1'b0, 1'b0, 20'h0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 32'h0FF0_0FF0, 1'b0); check_out();
        drive("and",   3'b000, 3'b111, 7'h20, 2'b00, 1'b0, 1'b0, 20'h0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 32'hF000_F000, 1'b0); check_out();
        drive("blt",   3'b100, 3'b100, 7'h00, 2'b00, 1'b0, 1'b1, 20'h0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd1, 1'b1); check_out();
        drive("bltu",  3'b100, 3'b110, 7'h00, 2'b00, 1'b0, 1'b1, 20'h0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b0); check_out();
        drive("blt_nobop", 3'b100, 3'b100, 7'h00, 2'b00, 1'b0, 1'b0, 20'h0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd1, 1'b0); check_out();
        drive("beq",   3'b100, 3'b000, 7'h00, 2'b00, 1'b0, 1'b1, 20'h0, 32'd9, 32'd9, 32'd0, 32'd1, 1'b1); check_out();
        drive("bgeu",  3'b100, 3'b111, 7'h00, 2'b00, 1'b0, 1'b1, 20'h0, 32'd3, 32'd9, 32'd0, 32'd0, 1'b0); check_out();
        drive("br_f3_010", 3'b100, 3'b010, 7'h00, 2'b00, 1'b0, 1'b1, 20'h0, 32'd9, 32'd9, 32'd0, 32'd0, 1'b0); check_out();
        drive("jal",   3'b011, 3'b000, 7'h00, 2'b10, 1'b1, 1'b0, 20'h00100, 32'h203, 32'd0, 32'd4, 32'h104, 1'b0); check_out();
        drive("lui",   3'b101, 3'b000, 7'h00, 2'b11, 1'b1, 1'b0, 20'h0, 32'd0, 32'd0, 32'h1234_5000, 32'h1234_5000, 1'b0); check_out();
        drive("auipc", 3'b110, 3'b000, 7'h00, 2'b01, 1'b1, 1'b0, 20'h00100, 32'd0, 32'd0, 32'h1000, 32'h1100, 1'b0); check_out();
        drive("zero_a", 3'b111, 3'b000, 7'h00, 2'b11, 1'b0, 1'b0, 20'h0, 32'hDEAD_BEEF, 32'd0, 32'd0, 32'd0, 1'b0); check_out();

        for (int i = 0; i < 5; i++) @(posedge clock);
        @(negedge clock);
        check_cycle("cnt_reset", 32'd0);
        reset = 1'b0;
        report = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clock);
            check_cycle("cnt_run", 32'(i));
        end
        reset = 1'b1;
        @(negedge clock);
        check_cycle("cnt_rereset", 32'd0);
        reset = 1'b0;
        @(negedge clock);
        check_cycle("cnt_restart", 32'd1);
        report = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
